// File: rtl/hs_npu_result_collector.sv
// Collects per-column accumulator results, de-skews them into complete rows and
// presents buffered rows downstream over a valid/ready handshake.
module hs_npu_result_collector #(
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int NUM_COLS          = 8,
  parameter int ROW_DEPTH         = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_COLS*OUTPUT_DATA_WIDTH-1:0] acc_result,
  input  logic [NUM_COLS-1:0]                   acc_valid,
  input  logic                                  flush,
  output logic [NUM_COLS*OUTPUT_DATA_WIDTH-1:0] row_data,
  output logic                                  row_valid,
  input  logic                                  row_ready,
  output logic                                  overflow,
  output logic                                  busy
);

  localparam int W  = OUTPUT_DATA_WIDTH;
  localparam int AW = $clog2(ROW_DEPTH);
  localparam int PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  // Handshake: a row transfers on any rising edge where row_valid && row_ready;
  // row_valid and row_data hold steady until that transfer, a flush or a reset.

  ptr_t                wp_q   [NUM_COLS];
  ptr_t                wp_d   [NUM_COLS];
  ptr_t                rp_q;
  ptr_t                rp_d;
  logic [NUM_COLS-1:0] mask_q [ROW_DEPTH];
  logic [NUM_COLS-1:0] mask_d [ROW_DEPTH];
  logic                ovf_q;
  logic                ovf_d;
  logic [W-1:0]        mem_q  [ROW_DEPTH][NUM_COLS];

  ptr_t                occ    [NUM_COLS];
  logic [NUM_COLS-1:0] col_accept;
  logic [NUM_COLS-1:0] col_drop;
  logic [AW-1:0]       rp_idx;
  logic                pop;

  assign rp_idx = rp_q[AW-1:0];

  // Occupancy is judged against the pre-pop read pointer, so a word aimed at
  // the entry being freed this same cycle is still counted as a drop.
  always_comb begin
    col_accept = '0;
    col_drop   = '0;
    for (int j = 0; j < NUM_COLS; j++) begin
      occ[j]        = wp_q[j] - rp_q;
      col_accept[j] = acc_valid[j] && (occ[j] < ptr_t'(ROW_DEPTH));
      col_drop[j]   = acc_valid[j] && !(occ[j] < ptr_t'(ROW_DEPTH));
    end
  end

  always_comb begin
    row_valid = &mask_q[rp_idx];
    for (int j = 0; j < NUM_COLS; j++) begin
      row_data[j*W +: W] = mem_q[rp_idx][j];
    end
  end

  assign pop = row_valid && row_ready;

  always_comb begin
    rp_d   = rp_q;
    wp_d   = wp_q;
    mask_d = mask_q;
    ovf_d  = ovf_q;
    if (flush) begin
      rp_d  = '0;
      ovf_d = 1'b0;
      for (int j = 0; j < NUM_COLS; j++) begin
        wp_d[j] = '0;
      end
      for (int r = 0; r < ROW_DEPTH; r++) begin
        mask_d[r] = '0;
      end
    end else begin
      if (pop) begin
        mask_d[rp_idx] = '0;
        rp_d           = rp_q + ptr_t'(1);
      end
      for (int j = 0; j < NUM_COLS; j++) begin
        if (col_accept[j]) begin
          mask_d[wp_q[j][AW-1:0]][j] = 1'b1;
          wp_d[j]                    = wp_q[j] + ptr_t'(1);
        end
      end
      if (|col_drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_q  <= '0;
      ovf_q <= 1'b0;
      for (int j = 0; j < NUM_COLS; j++) begin
        wp_q[j] <= '0;
      end
      for (int r = 0; r < ROW_DEPTH; r++) begin
        mask_q[r] <= '0;
      end
    end else begin
      rp_q   <= rp_d;
      ovf_q  <= ovf_d;
      wp_q   <= wp_d;
      mask_q <= mask_d;
    end
  end

  // Storage carries no reset; the fill masks alone decide what is meaningful.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_COLS; j++) begin
      if (!flush && col_accept[j]) begin
        mem_q[wp_q[j][AW-1:0]][j] <= acc_result[j*W +: W];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < ROW_DEPTH; r++) begin
      busy = busy | (|mask_q[r]);
    end
    for (int j = 0; j < NUM_COLS; j++) begin
      busy = busy | (wp_q[j] != rp_q);
    end
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_hs_npu_result_collector.sv
// Self-checking bench for hs_npu_result_collector: directed table, corner-case
// sequences and randomized traffic against a per-column queue model.
module tb_hs_npu_result_collector;

  localparam int W  = 32;
  localparam int NC = 8;
  localparam int RD = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NC*W-1:0] acc_result = '0;
  logic [NC-1:0]   acc_valid = '0;
  logic            flush = 1'b0;
  logic            row_ready = 1'b0;
  logic [NC*W-1:0] row_data;
  logic            row_valid;
  logic            overflow;
  logic            busy;

  hs_npu_result_collector #(
    .OUTPUT_DATA_WIDTH(W),
    .NUM_COLS(NC),
    .ROW_DEPTH(RD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .acc_result(acc_result),
    .acc_valid(acc_valid),
    .flush(flush),
    .row_data(row_data),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .overflow(overflow),
    .busy(busy)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  // model: each column holds the words it owns that have not yet left as a row
  logic [W-1:0] col_q [NC][$];
  logic         m_ovf = 1'b0;

  task automatic chk(input string name, input logic [NC*W-1:0] act, input logic [NC*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic m_rv();
    for (int j = 0; j < NC; j++) if (col_q[j].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_busy();
    for (int j = 0; j < NC; j++) if (col_q[j].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NC*W-1:0] m_row();
    logic [NC*W-1:0] r;
    r = '0;
    for (int j = 0; j < NC; j++) if (col_q[j].size() != 0) r[j*W +: W] = col_q[j][0];
    return r;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < NC; j++) col_q[j].delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    logic          rv;
    logic [NC-1:0] acc;
    if (flush) begin
      model_clear();
      return;
    end
    rv = m_rv();
    for (int j = 0; j < NC; j++) begin
      acc[j] = acc_valid[j] && (col_q[j].size() < RD);
      if (acc_valid[j] && !acc[j]) m_ovf = 1'b1;
    end
    if (rv && row_ready) begin
      for (int j = 0; j < NC; j++) void'(col_q[j].pop_front());
    end
    for (int j = 0; j < NC; j++) if (acc[j]) col_q[j].push_back(acc_result[j*W +: W]);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_rv"}, row_valid, m_rv());
    chk({tag, "_busy"}, busy, m_busy());
    chk({tag, "_ovf"}, overflow, m_ovf);
    if (m_rv()) chk({tag, "_data"}, row_data, m_row());
  endtask

  // driver tasks
  task automatic drive(input logic [NC-1:0] v, input logic [W-1:0] base, input logic rdy, input logic fl);
    acc_valid = v;
    row_ready = rdy;
    flush     = fl;
    for (int j = 0; j < NC; j++) acc_result[j*W +: W] = base + W'(j);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [NC*W-1:0] row_of(input logic [W-1:0] base);
    logic [NC*W-1:0] r;
    for (int j = 0; j < NC; j++) r[j*W +: W] = base + W'(j);
    return r;
  endfunction

  typedef struct {
    logic [NC-1:0] valid;
    logic [W-1:0]  base;
    logic          ready;
    logic          fl;
    logic          exp_rv;
    logic          exp_busy;
    logic          exp_ovf;
    logic [W-1:0]  exp_base;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int emitted;
    tbl[0] = '{8'hFF, 32'd100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd100};
    tbl[1] = '{8'h00, 32'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[2] = '{8'h0F, 32'd200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
    tbl[3] = '{8'hF0, 32'd200, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd200};
    tbl[4] = '{8'h00, 32'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd200};
    tbl[5] = '{8'h00, 32'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

    // reset state
    #12;
    chk("reset_rv", row_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ovf", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table: aligned row, split row, hold under backpressure, pop
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].valid, tbl[i].base, tbl[i].ready, tbl[i].fl);
      cycle();
      chk($sformatf("tbl%0d_rv", i), row_valid, tbl[i].exp_rv);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].exp_ovf);
      if (tbl[i].exp_rv) chk($sformatf("tbl%0d_data", i), row_data, row_of(tbl[i].exp_base));
      check_model($sformatf("tbl%0d_m", i));
    end

    // skewed rows: column j presents row r at cycle r+j
    for (int c = 0; c < 10; c++) begin
      drive('0, 0, 1'b1, 1'b0);
      for (int j = 0; j < NC; j++) begin
        if (c - j >= 0 && c - j <= 2) begin
          acc_valid[j] = 1'b1;
          acc_result[j*W +: W] = W'((c - j) * 16 + j);
        end
      end
      cycle();
      chk($sformatf("skew%0d_rv", c), row_valid, (c >= 7 && c <= 9));
      if (c >= 7) chk($sformatf("skew%0d_row", c), row_data[W-1:0], W'((c - 7) * 16));
      check_model($sformatf("skew%0d", c));
    end
    drive('0, 0, 1'b1, 1'b0);
    cycle();
    chk("skew_idle_busy", busy, 1'b0);

    // backpressure: four rows held, fifth column-0 word dropped
    for (int r = 0; r < 4; r++) begin
      drive(8'hFF, W'(300 + r * 16), 1'b0, 1'b0);
      cycle();
    end
    drive(8'h01, 32'h999, 1'b0, 1'b0);
    cycle();
    chk("bp_ovf", overflow, 1'b1);
    check_model("bp_full");
    drive('0, 0, 1'b1, 1'b0);
    emitted = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_rv%0d", k), row_valid, 1'b1);
      chk($sformatf("bp_row%0d", k), row_data, row_of(W'(300 + k * 16)));
      if (row_valid) emitted++;
      cycle();
    end
    chk("bp_emitted", emitted, 4);
    chk("bp_drained_rv", row_valid, 1'b0);
    chk("bp_drained_busy", busy, 1'b0);

    // pop collision: full buffer, pop row 0 while column 3 writes
    drive('0, 0, 1'b0, 1'b1);
    cycle();
    chk("pc_flush_ovf", overflow, 1'b0);
    for (int r = 0; r < 4; r++) begin
      drive(8'hFF, W'(400 + r * 16), 1'b0, 1'b0);
      cycle();
    end
    drive(8'h08, 32'hC0, 1'b1, 1'b0);
    cycle();
    chk("pc_ovf", overflow, 1'b1);
    chk("pc_next_row", row_data, row_of(W'(416)));
    check_model("pc_pop");
    drive(8'h08, 32'hD0, 1'b0, 1'b0);
    cycle();
    check_model("pc_refill");
    drive(8'hF7, 32'hD0, 1'b0, 1'b0);
    cycle();
    check_model("pc_complete");
    drive('0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) chk("pc_col3_word", row_data[3*W +: W], 32'hD3);
      cycle();
      check_model($sformatf("pc_drain%0d", k));
    end

    // flush mid-row with all columns valid in the flush cycle
    drive(8'h0F, 32'd600, 1'b1, 1'b0);
    cycle();
    chk("fl_partial_busy", busy, 1'b1);
    drive(8'hFF, 32'd700, 1'b1, 1'b1);
    cycle();
    chk("fl_busy", busy, 1'b0);
    chk("fl_ovf", overflow, 1'b0);
    chk("fl_rv", row_valid, 1'b0);
    drive(8'hFF, 32'd800, 1'b0, 1'b0);
    cycle();
    chk("fl_after_rv", row_valid, 1'b1);
    chk("fl_after_row", row_data, row_of(W'(800)));
    drive('0, 0, 1'b1, 1'b0);
    cycle();
    check_model("fl_drain");

    // async reset with two rows buffered and overflow set
    for (int r = 0; r < 2; r++) begin
      drive(8'hFF, W'(900 + r * 16), 1'b0, 1'b0);
      cycle();
    end
    for (int k = 0; k < 3; k++) begin
      drive(8'h01, W'(950 + k), 1'b0, 1'b0);
      cycle();
    end
    check_model("ar_pre");
    drive('0, 0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_rv", row_valid, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_ovf", overflow, 1'b0);
    model_clear();
    #3;
    rst_n = 1'b1;
    drive(8'hFF, 0, 1'b1, 1'b0);
    acc_result = {NC{32'hDEADBEEF}};
    cycle();
    chk("ar_new_rv", row_valid, 1'b1);
    chk("ar_new_row", row_data, {NC{32'hDEADBEEF}});
    drive('0, 0, 1'b1, 1'b0);
    cycle();
    chk("ar_alone_rv", row_valid, 1'b0);
    chk("ar_alone_busy", busy, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < NC; j++) begin
        acc_valid[j] = ($urandom_range(0, 9) < 7);
        acc_result[j*W +: W] = $urandom;
      end
      row_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      cycle();
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
